// File: rtl/cpu_pkg.sv
// Shared definitions for the XOR response checker: FSM encoding, tally width,
// and the saturating increment used by the pass/fail counters.
package cpu_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/exp_fifo.sv
// Expectation FIFO: holds the XOR of each accepted operand pair until the
// matching result arrives.
// Ports:
//   clk, rst_n      clock, async active-low reset (empties the FIFO)
//   clr             synchronous flush
//   push, din       write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head            current head entry, read from registered storage
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
module exp_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  // Storage; DEPTH is a power of two so the pointers wrap on overflow.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/xor_resp_checker.sv
// Scoreboard for an XOR unit: operand pairs are pushed in, their expected
// XOR is queued, and returned results are compared in order against the queue.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, stop                 begin a run (clears tallies) / stop accepting operands
//   op_valid/op_ready/in1/in2   operand push handshake
//   res_valid/res_ready/result  result pop handshake
//   pass_cnt, fail_cnt          saturating compare tallies
//   err, err_exp, err_got, err_idx  sticky first-mismatch capture
//   unexp                       sticky: result arrived with nothing outstanding
//   busy, done                  RUN/DRAIN and DONE indicators
module xor_resp_checker
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic [CNT_W-1:0] err_idx,
  output logic             unexp,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t           state_q;
  state_t           state_n;
  logic             push;
  logic             cmp;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    cnt_n;
  logic             full_n;
  logic [WIDTH-1:0] head;

  // A start cycle flushes everything, so handshakes in that cycle are ignored.
  assign push = op_valid && op_ready && !start && !fifo_full;
  assign cmp  = res_valid && res_ready && !start;
  assign pop  = cmp && !fifo_empty;

  exp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .push  (push),
    .din   (in1 ^ in2),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Occupancy after this edge, so the registered op_ready is exact next cycle.
  always_comb begin
    cnt_n  = start ? '0 : (fifo_cnt + CW'(push) - CW'(pop));
    full_n = (cnt_n == CW'(DEPTH));
  end

  // Next-state logic; start wins from every state.
  always_comb begin
    state_n = state_q;
    if (start) begin
      state_n = ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_n = ST_IDLE;
        ST_RUN:   if (stop) state_n = ST_DRAIN;
        ST_DRAIN: if (fifo_empty) state_n = ST_DONE;
        ST_DONE:  state_n = ST_DONE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_ready  <= 1'b0;
      res_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      op_ready  <= (state_n == ST_RUN) && !full_n;
      res_ready <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      busy      <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done      <= (state_n == ST_DONE);
    end
  end

  // Compare tallies and first-mismatch capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      err_exp  <= '0;
      err_got  <= '0;
      err_idx  <= '0;
      unexp    <= 1'b0;
    end else if (start) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      err_exp  <= '0;
      err_got  <= '0;
      err_idx  <= '0;
      unexp    <= 1'b0;
    end else if (cmp) begin
      if (fifo_empty) begin
        unexp <= 1'b1;
      end else if (head == result) begin
        pass_cnt <= sat_inc(pass_cnt);
      end else begin
        fail_cnt <= sat_inc(fail_cnt);
        if (!err) begin
          err     <= 1'b1;
          err_exp <= head;
          err_got <= result;
          err_idx <= pass_cnt + fail_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_resp_checker.sv
// Bench for xor_resp_checker: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_xor_resp_checker;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [WIDTH-1:0] in1 = '0;
  logic [WIDTH-1:0] in2 = '0;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic [WIDTH-1:0] result = '0;
  logic [15:0]      pass_cnt;
  logic [15:0]      fail_cnt;
  logic             err;
  logic [WIDTH-1:0] err_exp;
  logic [WIDTH-1:0] err_got;
  logic [15:0]      err_idx;
  logic             unexp;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  xor_resp_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .op_valid(op_valid), .op_ready(op_ready), .in1(in1), .in2(in2),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .err_exp(err_exp),
    .err_got(err_got), .err_idx(err_idx), .unexp(unexp), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
  mstate_t          m_st = M_IDLE;
  logic [WIDTH-1:0] m_q[$];
  logic [15:0]      m_pass = '0, m_fail = '0, m_idx = '0;
  logic [WIDTH-1:0] m_exp = '0, m_got = '0;
  logic             m_err = 1'b0, m_unexp = 1'b0;
  logic             m_op_ready = 1'b0, m_res_ready = 1'b0;

  task automatic model_clear();
    m_q.delete();
    m_pass = '0; m_fail = '0; m_idx = '0;
    m_exp = '0; m_got = '0; m_err = 1'b0; m_unexp = 1'b0;
  endtask

  task automatic model_step();
    bit hp, hr;
    int occ;
    logic [WIDTH-1:0] e;
    hp  = op_valid && m_op_ready && !start;
    hr  = res_valid && m_res_ready && !start;
    occ = m_q.size();
    if (start) begin
      model_clear();
      m_st = M_RUN;
    end else begin
      if (hr) begin
        if (occ == 0) m_unexp = 1'b1;
        else begin
          e = m_q.pop_front();
          if (e == result) begin
            if (m_pass != 16'hFFFF) m_pass = m_pass + 16'd1;
          end else begin
            if (!m_err) begin
              m_err = 1'b1; m_exp = e; m_got = result; m_idx = m_pass + m_fail;
            end
            if (m_fail != 16'hFFFF) m_fail = m_fail + 16'd1;
          end
        end
      end
      if (hp) m_q.push_back(in1 ^ in2);
      if (m_st == M_RUN && stop) m_st = M_DRAIN;
      else if (m_st == M_DRAIN && occ == 0) m_st = M_DONE;
    end
    m_op_ready  = (m_st == M_RUN) && (m_q.size() < DEPTH);
    m_res_ready = (m_st == M_RUN) || (m_st == M_DRAIN);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
        m_st = M_IDLE; m_op_ready = 1'b0; m_res_ready = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("op_ready",  32'(op_ready),  32'(m_op_ready));
      chk("res_ready", 32'(res_ready), 32'(m_res_ready));
      chk("pass_cnt",  32'(pass_cnt),  32'(m_pass));
      chk("fail_cnt",  32'(fail_cnt),  32'(m_fail));
      chk("err",       32'(err),       32'(m_err));
      chk("err_exp",   32'(err_exp),   32'(m_exp));
      chk("err_got",   32'(err_got),   32'(m_got));
      chk("err_idx",   32'(err_idx),   32'(m_idx));
      chk("unexp",     32'(unexp),     32'(m_unexp));
      chk("busy",      32'(busy),      32'((m_st == M_RUN) || (m_st == M_DRAIN)));
      chk("done",      32'(done),      32'(m_st == M_DONE));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("push_timeout", 32'(1), 32'(0));
    end else begin
      op_valid = 1'b1; in1 = a; in2 = b;
      @(negedge clk); op_valid = 1'b0;
    end
  endtask

  task automatic do_res(input logic [WIDTH-1:0] r);
    int n = 0;
    @(negedge clk);
    while (!res_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("res_timeout", 32'(1), 32'(0));
    end else begin
      res_valid = 1'b1; result = r;
      @(negedge clk); res_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'(0));
    chk("rst_busy",     32'(busy),     32'(0));
    chk("rst_pass",     32'(pass_cnt), 32'(0));
    rst_n = 1'b1;

    // In-order matches.
    pulse_start();
    chk("run_busy", 32'(busy), 32'(1));
    chk("run_op_ready", 32'(op_ready), 32'(1));
    do_push(16'd2, 16'd3); do_push(16'd6, 16'd2); do_push(16'd10, 16'd10);
    do_res(16'd1); do_res(16'd4); do_res(16'd0);
    chk("s1_pass", 32'(pass_cnt), 32'(3));
    chk("s1_fail", 32'(fail_cnt), 32'(0));
    chk("s1_err",  32'(err),      32'(0));

    // First mismatch capture, second mismatch leaves it alone.
    pulse_start();
    do_push(16'd5, 16'd9); do_res(16'd13);
    chk("s2_fail", 32'(fail_cnt), 32'(1));
    chk("s2_err",  32'(err),      32'(1));
    chk("s2_exp",  32'(err_exp),  32'(12));
    chk("s2_got",  32'(err_got),  32'(13));
    chk("s2_idx",  32'(err_idx),  32'(0));
    do_push(16'd7, 16'd1); do_res(16'd5);
    chk("s2b_fail", 32'(fail_cnt), 32'(2));
    chk("s2b_exp",  32'(err_exp),  32'(12));
    chk("s2b_got",  32'(err_got),  32'(13));

    // Full FIFO; pop while offering an operand must not accept it.
    pulse_start();
    do_push(16'd1, 16'd0); do_push(16'd2, 16'd0); do_push(16'd3, 16'd0); do_push(16'd4, 16'd0);
    chk("s3_full_ready", 32'(op_ready), 32'(0));
    res_valid = 1'b1; result = 16'd1; op_valid = 1'b1; in1 = 16'd9; in2 = 16'd9;
    @(negedge clk);
    res_valid = 1'b0; op_valid = 1'b0;
    chk("s3_ready_back", 32'(op_ready), 32'(1));
    chk("s3_pass1",      32'(pass_cnt), 32'(1));
    do_res(16'd2); do_res(16'd3); do_res(16'd4);
    chk("s3_pass4", 32'(pass_cnt), 32'(4));
    chk("s3_fail",  32'(fail_cnt), 32'(0));

    // Unexpected result with empty FIFO.
    do_res(16'd7);
    chk("s4_unexp", 32'(unexp),    32'(1));
    chk("s4_pass",  32'(pass_cnt), 32'(4));
    chk("s4_fail",  32'(fail_cnt), 32'(0));

    // Stop and drain.
    pulse_start();
    do_push(16'd15, 16'd15); do_push(16'd10, 16'd6);
    pulse_stop();
    chk("s5_drain_busy", 32'(busy),     32'(1));
    chk("s5_drain_done", 32'(done),     32'(0));
    chk("s5_drain_opr",  32'(op_ready), 32'(0));
    do_res(16'd0); do_res(16'd12);
    @(negedge clk);
    chk("s5_done", 32'(done),     32'(1));
    chk("s5_busy", 32'(busy),     32'(0));
    chk("s5_pass", 32'(pass_cnt), 32'(2));

    // Reset mid-run discards outstanding work.
    pulse_start();
    do_push(16'd1, 16'd1); do_push(16'd2, 16'd2);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_opr",  32'(op_ready),  32'(0));
    chk("s6_rst_resr", 32'(res_ready), 32'(0));
    chk("s6_rst_busy", 32'(busy),      32'(0));
    chk("s6_rst_done", 32'(done),      32'(0));
    chk("s6_rst_pass", 32'(pass_cnt),  32'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    do_push(16'd1, 16'd3); do_res(16'd2);
    chk("s6_pass", 32'(pass_cnt), 32'(1));
    chk("s6_fail", 32'(fail_cnt), 32'(0));
    chk("s6_unexp", 32'(unexp),   32'(0));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
